// File: rtl/pixel_ram_dp.sv
// pixel_ram_dp: single-clock pixel buffer with byte-lane writes, registered
// reads and a self-running fill engine. After reset, or when clear is
// requested, every word is rewritten with INIT_COLOR, one word per cycle.
// External traffic is locked out while the fill runs.
module pixel_ram_dp #(
  parameter int              AW         = 4,
  parameter int              DW         = 24,
  parameter int              DEPTH      = 14,
  parameter logic [DW-1:0]   INIT_COLOR = DW'(24'hFF0000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DW-1:0]     wr_data,
  input  logic [DW/8-1:0]   wr_be,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  input  logic              clear,
  output logic [DW-1:0]     rd_data,
  output logic              rd_valid,
  output logic              busy
);

  localparam int unsigned NB = DW / 8;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FILL = 1'b1;

  // Last fill address and an (AW+1)-bit depth so DEPTH == 2**AW compares correctly.
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);

  logic [0:0]    state;
  logic [AW-1:0] fill_cnt;
  logic [DW-1:0] mem [DEPTH];

  logic          wr_in_range;
  logic          rd_in_range;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic          wr_go;
  logic [DW-1:0] wr_word;
  logic [DW-1:0] rd_word;

  // Address qualification; out-of-range addresses are steered to word 0 so
  // the array is never indexed past its end (their results are discarded).
  always_comb begin
    wr_in_range = ({1'b0, wr_addr} < DEPTH_W);
    rd_in_range = ({1'b0, rd_addr} < DEPTH_W);
    wr_idx      = wr_in_range ? wr_addr : '0;
    rd_idx      = rd_in_range ? rd_addr : '0;
    // clear wins over a coincident write
    wr_go       = (state == IDLE) && wr_en && !clear && wr_in_range;
  end

  // Byte-lane merge of the incoming write with the stored word.
  always_comb begin
    wr_word = mem[wr_idx];
    for (int unsigned i = 0; i < NB; i++) begin
      if (wr_be[i]) begin
        wr_word[8*i +: 8] = wr_data[8*i +: 8];
      end
    end
  end

  // Read source with write-first forwarding on a same-address collision.
  always_comb begin
    rd_word = mem[rd_idx];
    if (wr_go && (wr_addr == rd_addr)) begin
      rd_word = wr_word;
    end
  end

  // Fill/idle sequencing; clear during a fill restarts it from address 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FILL;
      fill_cnt <= '0;
    end else begin
      case (state)
        FILL: begin
          if (clear) begin
            fill_cnt <= '0;
          end else if (fill_cnt == LAST) begin
            state    <= IDLE;
            fill_cnt <= '0;
          end else begin
            fill_cnt <= fill_cnt + 1'b1;
          end
        end
        default: begin
          if (clear) begin
            state    <= FILL;
            fill_cnt <= '0;
          end
        end
      endcase
    end
  end

  // Array writes: the fill engine owns the array in FILL, external writes in IDLE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == FILL) begin
        mem[fill_cnt] <= INIT_COLOR;
      end else if (wr_go) begin
        mem[wr_addr] <= wr_word;
      end
    end
  end

  // Registered read port; data holds when no read is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if ((state == IDLE) && rd_en) begin
      rd_valid <= 1'b1;
      rd_data  <= rd_in_range ? rd_word : '0;
    end else begin
      rd_valid <= 1'b0;
    end
  end

  // busy mirrors the fill state.
  always_comb begin
    busy = (state == FILL);
  end

endmodule

// File: tb/tb_pixel_ram_dp.sv
// tb_pixel_ram_dp: scenario tasks plus randomized traffic checked against a
// word-array reference model of the pixel buffer.
module tb_pixel_ram_dp;

  localparam int          DEPTH = 14;
  localparam logic [23:0] INIT  = 24'hFF0000;

  logic        clk = 1'b0;
  logic        rst, wr_en, rd_en, clear;
  logic [3:0]  wr_addr, rd_addr;
  logic [23:0] wr_data;
  logic [2:0]  wr_be;
  logic [23:0] rd_data;
  logic        rd_valid, busy;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [23:0] m [DEPTH];
  int          fill_left = 0;
  logic        e_valid = 1'b0;
  logic [23:0] e_data  = '0;
  logic        e_busy  = 1'b0;

  pixel_ram_dp #(.AW(4), .DW(24), .DEPTH(14), .INIT_COLOR(24'hFF0000)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .clear(clear),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] lane_mix(input logic [23:0] old_w, input logic [23:0] new_w,
                                           input logic [2:0] be);
    logic [23:0] r;
    r = old_w;
    for (int i = 0; i < 3; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  // Drive one cycle of inputs, clock it, and advance the reference model.
  task automatic tick(input logic r, input logic w, input logic [3:0] wa, input logic [23:0] wd,
                      input logic [2:0] be, input logic re, input logic [3:0] ra, input logic cl);
    logic [23:0] v;
    rst = r; wr_en = w; wr_addr = wa; wr_data = wd; wr_be = be;
    rd_en = re; rd_addr = ra; clear = cl;
    @(posedge clk);
    if (r) begin
      fill_left = DEPTH; e_valid = 1'b0; e_data = '0;
    end else if (fill_left > 0) begin
      e_valid = 1'b0;
      if (cl) fill_left = DEPTH;
      else begin
        fill_left--;
        if (fill_left == 0) for (int i = 0; i < DEPTH; i++) m[i] = INIT;
      end
    end else begin
      e_valid = re;
      if (re) begin
        if (int'(ra) < DEPTH) begin
          v = m[ra];
          if (w && !cl && wa == ra) v = lane_mix(v, wd, be);
          e_data = v;
        end else e_data = '0;
      end
      if (w && !cl && int'(wa) < DEPTH) m[wa] = lane_mix(m[wa], wd, be);
      if (cl) fill_left = DEPTH;
    end
    e_busy = (fill_left > 0);
    #1;
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 4'd0, 24'd0, 3'd0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic rd(input logic [3:0] a);
    tick(1'b0, 1'b0, 4'd0, 24'd0, 3'd0, 1'b1, a, 1'b0);
  endtask

  task automatic test_reset();
    int n;
    tick(1'b1, 1'b0, 4'd0, 24'd0, 3'd0, 1'b0, 4'd0, 1'b0);
    tick(1'b1, 1'b1, 4'd3, 24'h111111, 3'b111, 1'b1, 4'd3, 1'b0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy got=%b exp=1", busy); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", rd_valid); end
    total++; if (rd_data !== 24'h0) begin bad++; $display("FAIL reset_data got=%h exp=000000", rd_data); end
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      tick(1'b0, 1'b1, 4'd2, 24'h222222, 3'b111, 1'b1, 4'd2, 1'b0);
      n++;
      total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_fill_valid got=%b exp=0", rd_valid); end
    end
    total++; if (n != 14) begin bad++; $display("FAIL reset_busy_len got=%0d exp=14", n); end
  endtask

  task automatic test_fill_contents();
    for (int a = 0; a < DEPTH; a++) begin
      rd(4'(a));
      total++;
      if (rd_valid !== 1'b1 || rd_data !== 24'hFF0000) begin
        bad++; $display("FAIL fill_read addr=%0d got=%b/%h exp=1/ff0000", a, rd_valid, rd_data);
      end
    end
    idle();
    total++;
    if (rd_valid !== 1'b0 || rd_data !== 24'hFF0000) begin
      bad++; $display("FAIL read_hold got=%b/%h exp=0/ff0000", rd_valid, rd_data);
    end
  endtask

  task automatic test_byte_lanes();
    tick(1'b0, 1'b1, 4'd5, 24'h123456, 3'b111, 1'b0, 4'd0, 1'b0);
    tick(1'b0, 1'b1, 4'd5, 24'hABCDEF, 3'b010, 1'b0, 4'd0, 1'b0);
    tick(1'b0, 1'b1, 4'd5, 24'h999999, 3'b000, 1'b0, 4'd0, 1'b0);
    rd(4'd5);
    total++;
    if (rd_valid !== 1'b1 || rd_data !== 24'h12CD56) begin
      bad++; $display("FAIL byte_lanes got=%b/%h exp=1/12cd56", rd_valid, rd_data);
    end
  endtask

  task automatic test_same_cycle();
    tick(1'b0, 1'b1, 4'd7, 24'h00FF00, 3'b111, 1'b1, 4'd7, 1'b0);
    total++;
    if (rd_valid !== 1'b1 || rd_data !== 24'h00FF00) begin
      bad++; $display("FAIL write_first got=%b/%h exp=1/00ff00", rd_valid, rd_data);
    end
    tick(1'b0, 1'b1, 4'd3, 24'h0A0B0C, 3'b101, 1'b1, 4'd9, 1'b0);
    total++;
    if (rd_data !== 24'hFF0000) begin bad++; $display("FAIL diff_addr_read got=%h exp=ff0000", rd_data); end
    rd(4'd15);
    total++;
    if (rd_valid !== 1'b1 || rd_data !== 24'h000000) begin
      bad++; $display("FAIL oob_read got=%b/%h exp=1/000000", rd_valid, rd_data);
    end
    tick(1'b0, 1'b1, 4'd14, 24'h5A5A5A, 3'b111, 1'b0, 4'd0, 1'b0);
    tick(1'b0, 1'b1, 4'd15, 24'hA5A5A5, 3'b111, 1'b0, 4'd0, 1'b0);
    for (int a = 0; a < DEPTH; a++) begin
      rd(4'(a));
      total++;
      if (rd_data !== e_data) begin bad++; $display("FAIL no_alias addr=%0d got=%h exp=%h", a, rd_data, e_data); end
    end
  endtask

  task automatic test_random();
    logic w, re, cl;
    logic [3:0] wa, ra;
    for (int k = 0; k < 400; k++) begin
      w  = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      cl = ($urandom_range(0, 39) == 0);
      wa = 4'($urandom_range(0, 15));
      ra = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
      tick(1'b0, w, wa, 24'($urandom), 3'($urandom_range(0, 7)), re, ra, cl);
      total++;
      if (busy !== e_busy || rd_valid !== e_valid || rd_data !== e_data) begin
        bad++;
        $display("FAIL random cyc=%0d got=%b/%b/%h exp=%b/%b/%h", k, busy, rd_valid, rd_data,
                 e_busy, e_valid, e_data);
      end
    end
    for (int k = 0; k < 40 && busy === 1'b1; k++) idle();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL random_drain got=%b exp=0", busy); end
  endtask

  task automatic test_clear();
    int n;
    tick(1'b0, 1'b1, 4'd1, 24'h010203, 3'b111, 1'b0, 4'd0, 1'b0);
    tick(1'b0, 1'b1, 4'd13, 24'h0D0E0F, 3'b111, 1'b0, 4'd0, 1'b0);
    tick(1'b0, 1'b1, 4'd2, 24'h777777, 3'b111, 1'b0, 4'd0, 1'b1);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL clear_busy got=%b exp=1", busy); end
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      tick(1'b0, 1'b1, 4'($urandom_range(0, 13)), 24'h333333, 3'b111, 1'b1, 4'($urandom_range(0, 13)), 1'b0);
      n++;
      total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL clear_fill_valid got=%b exp=0", rd_valid); end
    end
    total++; if (n != 14) begin bad++; $display("FAIL clear_busy_len got=%0d exp=14", n); end
    for (int a = 0; a < DEPTH; a++) begin
      rd(4'(a));
      total++;
      if (rd_valid !== 1'b1 || rd_data !== 24'hFF0000) begin
        bad++; $display("FAIL clear_read addr=%0d got=%b/%h exp=1/ff0000", a, rd_valid, rd_data);
      end
    end
  endtask

  task automatic test_restart();
    int n;
    tick(1'b0, 1'b0, 4'd0, 24'd0, 3'd0, 1'b0, 4'd0, 1'b1);
    for (int k = 0; k < 5; k++) idle();
    tick(1'b1, 1'b0, 4'd0, 24'd0, 3'd0, 1'b0, 4'd0, 1'b0);
    n = 0;
    while (busy === 1'b1 && n < 9) begin idle(); n++; end
    total++; if (busy !== 1'b1 || n != 9) begin bad++; $display("FAIL rst_mid_fill got=%b/%0d exp=1/9", busy, n); end
    tick(1'b0, 1'b0, 4'd0, 24'd0, 3'd0, 1'b0, 4'd0, 1'b1);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      idle(); n++;
      total++; if (busy !== e_busy) begin bad++; $display("FAIL restart_busy n=%0d got=%b exp=%b", n, busy, e_busy); end
    end
    total++; if (n != 14) begin bad++; $display("FAIL restart_busy_len got=%0d exp=14", n); end
    rd(4'd6);
    total++;
    if (rd_valid !== 1'b1 || rd_data !== 24'hFF0000) begin
      bad++; $display("FAIL restart_read got=%b/%h exp=1/ff0000", rd_valid, rd_data);
    end
  endtask

  initial begin
    test_reset();
    test_fill_contents();
    test_byte_lanes();
    test_same_cycle();
    test_random();
    test_clear();
    test_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pixel_ram_dp.md
PIXEL_RAM_DP -- requirements
Module: pixel_ram_dp

Interface
REQ-001 The block SHALL have parameter AW, default 4, meaning address width in bits.
REQ-002 The block SHALL have parameter DW, default 24, meaning data width in bits; DW SHALL be a multiple of 8.
REQ-003 The block SHALL have parameter DEPTH, default 14, meaning number of words; 1 <= DEPTH <= 2**AW.
REQ-004 The block SHALL have parameter INIT_COLOR, default 24'hFF0000 (DW bits), meaning fill value.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset: clk input 1 (all logic on rising edge); rst input 1.
REQ-006 The block SHALL have the port wr_en input 1: write request.
REQ-007 The block SHALL have the port wr_addr input AW: write address.
REQ-008 The block SHALL have the port wr_data input DW: write data.
REQ-009 The block SHALL have the port wr_be input DW/8: byte-lane write enables; bit i covers bits [8i+7:8i].
REQ-010 The block SHALL have the port rd_en input 1: read request.
REQ-011 The block SHALL have the port rd_addr input AW: read address.
REQ-012 The block SHALL have the port clear input 1: request refill of the whole array with INIT_COLOR.
REQ-013 The block SHALL have the port rd_data output DW: registered read data.
REQ-014 The block SHALL have the port rd_valid output 1: one-cycle pulse qualifying rd_data.
REQ-015 The block SHALL have the port busy output 1: high while fill is in progress.

Function
REQ-016 The FSM SHALL have two states, FILL and IDLE; rst forces FILL with fill counter = 0.
REQ-017 In FILL, one word per cycle SHALL be written with INIT_COLOR at the fill counter, which increments by 1; after writing address DEPTH-1 the FSM SHALL enter IDLE on the next edge (DEPTH cycles in FILL).
REQ-018 In IDLE, clear=1 SHALL enter FILL with counter 0; clear=1 in FILL SHALL restart the counter at 0.
REQ-019 busy SHALL equal 1 exactly while the state is FILL.
REQ-020 In FILL, external writes SHALL be dropped and read requests SHALL be ignored (rd_valid stays 0, rd_data holds).
REQ-021 In IDLE, wr_en=1 with wr_addr < DEPTH SHALL update only the byte lanes with wr_be set; lanes with wr_be clear SHALL keep their old value; wr_be = 0 SHALL leave the word unchanged.
REQ-022 wr_addr >= DEPTH SHALL be ignored, with no write and no aliasing.
REQ-023 In IDLE, rd_en=1 SHALL produce rd_data and rd_valid=1 exactly one cycle later (latency 1); rd_en=0 SHALL give rd_valid=0 next cycle and rd_data holding its previous value.
REQ-024 rd_addr >= DEPTH SHALL return rd_data = 0 with rd_valid=1.
REQ-025 Read and write in the same cycle at the same in-range address SHALL return write-first data: enabled lanes from wr_data, other lanes from memory.
REQ-026 Read and write in the same cycle at different addresses SHALL both complete independently.
REQ-027 clear and wr_en in the same IDLE cycle: clear SHALL take priority and the write SHALL be dropped.

Reset
REQ-028 On a clk edge with rst=1: state = FILL, fill counter = 0, busy = 1, rd_valid = 0, rd_data = 0.
REQ-029 rst asserted mid-fill or mid-operation SHALL restart the fill from address 0; array contents are not otherwise cleared by rst.
REQ-030 The first IDLE cycle SHALL occur DEPTH cycles after rst deasserts.

Verification (DEPTH=14, AW=4, DW=24)
REQ-031 Reset release -> busy=1 for 14 cycles then 0; reads of addr 0..13 each return 24'hFF0000 with rd_valid one cycle after rd_en.
REQ-032 Write 24'h123456 at addr 5 with wr_be=3'b111, then wr_data=24'hABCDEF at addr 5 with wr_be=3'b010 -> read addr 5 returns 24'h12CD56.
REQ-033 Same cycle write 24'h00FF00 (be=3'b111) and read at addr 7 -> rd_data=24'h00FF00 next cycle; read of addr 15 -> 24'h000000 with rd_valid=1; write to addr 14 -> no array change.
REQ-034 clear pulse in IDLE after writes -> busy=1 for 14 cycles; wr_en/rd_en during fill produce no write and rd_valid=0; afterwards all words read 24'hFF0000.
REQ-035 rst at fill cycle 6, released -> busy stays 1 for a further 14 cycles; clear re-asserted at fill cycle 10 -> fill restarts, busy 1 for 14 more cycles.
